// File: rtl/relu_grad_gate_if.sv
// Stream bundle for the ReLU gradient gate: forward z, backward delta, gated output.
// The master side drives z/delta/out_ready; the gate is the slave.
interface relu_grad_gate_if #(
    parameter int dataWidth = 32
);
    logic                 fwd_valid;
    logic [dataWidth-1:0] fwd_z;
    logic                 fwd_ready;
    logic                 bwd_valid;
    logic [dataWidth-1:0] bwd_delta;
    logic                 bwd_ready;
    logic                 out_valid;
    logic [dataWidth-1:0] out_data;
    logic                 out_ready;

    modport master (
        output fwd_valid, fwd_z, bwd_valid, bwd_delta, out_ready,
        input  fwd_ready, bwd_ready, out_valid, out_data
    );

    modport slave (
        input  fwd_valid, fwd_z, bwd_valid, bwd_delta, out_ready,
        output fwd_ready, bwd_ready, out_valid, out_data
    );
endinterface

// File: rtl/relu_grad_gate.sv
// ReLU backward gate: stores one "z > 0" bit per forward FP32 value in a FIFO and
// uses it to pass or zero the matching backward gradient through a 1-deep output register.
module relu_grad_gate #(
    parameter int dataWidth = 32,
    parameter int depth     = 64,
    parameter int cntWidth  = $clog2(depth) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    relu_grad_gate_if.slave     bus,
    output logic [cntWidth-1:0] mask_count,
    output logic                err_underrun
);
    localparam int PtrWidth = $clog2(depth);
    localparam int ExpMsb   = dataWidth - 2;
    localparam int ExpLsb   = dataWidth - 9;

    logic [depth-1:0]     r_mask_mem;
    logic [PtrWidth-1:0]  r_wr_ptr;
    logic [PtrWidth-1:0]  r_rd_ptr;
    logic [cntWidth-1:0]  r_count;
    logic                 r_out_valid;
    logic [dataWidth-1:0] r_out_data;
    logic                 r_err;

    logic w_sign;
    logic w_mag_nz;
    logic w_exp_ones;
    logic w_man_nz;
    logic w_is_nan;
    logic w_mask_in;
    logic w_head;
    logic w_empty;
    logic w_full;
    logic w_out_free;
    logic w_push;
    logic w_pop;
    logic w_underrun;

    // z > 0 without any FP arithmetic: positive sign, not +-0, not NaN (+inf passes)
    assign w_sign     = bus.fwd_z[dataWidth-1];
    assign w_mag_nz   = |bus.fwd_z[dataWidth-2:0];
    assign w_exp_ones = &bus.fwd_z[ExpMsb:ExpLsb];
    assign w_man_nz   = |bus.fwd_z[ExpLsb-1:0];
    assign w_is_nan   = w_exp_ones & w_man_nz;
    assign w_mask_in  = ~w_sign & w_mag_nz & ~w_is_nan;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == cntWidth'(depth));
    assign w_out_free = ~r_out_valid | bus.out_ready;

    // Full blocks pushes even when a pop frees a slot this cycle, keeping fwd_ready registered-only
    assign w_push     = bus.fwd_valid & ~w_full;
    assign w_pop      = bus.bwd_valid & ~w_empty & w_out_free;
    assign w_underrun = bus.bwd_valid & w_empty & w_out_free;
    assign w_head     = r_mask_mem[r_rd_ptr];

    assign bus.fwd_ready = ~w_full;
    assign bus.bwd_ready = ~w_empty & w_out_free;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign mask_count    = r_count;
    assign err_underrun  = r_err;

    // Mask storage carries no reset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mask_mem[r_wr_ptr] <= w_mask_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cntWidth'(1);
                2'b01:   r_count <= r_count - cntWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head ? bus.bwd_delta : '0;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_underrun) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_relu_grad_gate.sv
// Scenario bench for relu_grad_gate: a negedge monitor keeps a mask/expected-output
// scoreboard while each scenario task also checks its own boundary values inline.
module tb_relu_grad_gate;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush;
    logic [6:0] mask_count;
    logic       err_underrun;

    int errors = 0;
    int checks = 0;

    bit          mask_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    bit          mon_popped = 1'b0;

    relu_grad_gate_if #(.dataWidth(32)) bus ();

    relu_grad_gate #(.dataWidth(32), .depth(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus.slave),
        .mask_count   (mask_count),
        .err_underrun (err_underrun)
    );

    always #5 clk = ~clk;

    function automatic bit ref_mask(input logic [31:0] z);
        bit is_nan;
        is_nan = (z[30:23] == 8'hFF) && (z[22:0] != 23'd0);
        return (z[31] == 1'b0) && (z[30:0] != 31'd0) && !is_nan;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.fwd_valid = 1'b0;
        bus.fwd_z     = 32'd0;
        bus.bwd_valid = 1'b0;
        bus.bwd_delta = 32'd0;
        bus.out_ready = 1'b1;
        flush         = 1'b0;
    endtask

    task automatic monitor();
        bit          m;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst || flush) begin
                mask_q.delete();
                exp_q.delete();
                mon_popped = 1'b0;
                continue;
            end
            checks++;
            if (int'(mask_count) != mask_q.size()) begin
                errors++;
                $display("FAIL count_track: mask_count=%0d model=%0d", mask_count, mask_q.size());
            end
            if (mon_popped) begin
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency: out_valid=%b one cycle after accept, want 1", bus.out_valid);
                end
            end
            mon_popped = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: out_data=%h with nothing expected", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    obs_q.push_back(bus.out_data);
                    if (bus.out_data !== e) begin
                        errors++;
                        $display("FAIL out_data: got %h want %h", bus.out_data, e);
                    end
                end
            end
            if (bus.bwd_valid && bus.bwd_ready) begin
                if (mask_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL pop_empty: bwd accepted with model FIFO empty");
                end else begin
                    m = mask_q.pop_front();
                    exp_q.push_back(m ? bus.bwd_delta : 32'd0);
                    mon_popped = 1'b1;
                end
            end
            if (bus.fwd_valid && bus.fwd_ready) begin
                mask_q.push_back(ref_mask(bus.fwd_z));
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        checks += 6;
        if (mask_count !== 7'd0)      begin errors++; $display("FAIL rst_count: got %0d want 0", mask_count); end
        if (bus.out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        if (bus.out_data !== 32'd0)   begin errors++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
        if (err_underrun !== 1'b0)    begin errors++; $display("FAIL rst_err: got %b want 0", err_underrun); end
        if (bus.fwd_ready !== 1'b1)   begin errors++; $display("FAIL rst_fwd_ready: got %b want 1", bus.fwd_ready); end
        if (bus.bwd_ready !== 1'b0)   begin errors++; $display("FAIL rst_bwd_ready: got %b want 0", bus.bwd_ready); end
        @(posedge clk);
        #1 rst = 1'b1;
        step();
    endtask

    task automatic test_gating();
        logic [31:0] zs  [6];
        logic [31:0] req [6];
        zs[0] = 32'h3F800000; zs[1] = 32'hBF800000; zs[2] = 32'h00000000;
        zs[3] = 32'h80000000; zs[4] = 32'h7F800000; zs[5] = 32'h7FC00000;
        req[0] = 32'h40000000; req[1] = 32'd0; req[2] = 32'd0;
        req[3] = 32'd0;        req[4] = 32'h40000000; req[5] = 32'd0;
        obs_q.delete();
        for (int i = 0; i < 6; i++) begin
            bus.fwd_valid = 1'b1;
            bus.fwd_z     = zs[i];
            step();
        end
        bus.fwd_valid = 1'b0;
        checks++;
        if (mask_count !== 7'd6) begin errors++; $display("FAIL gate_count: got %0d want 6", mask_count); end
        for (int i = 0; i < 6; i++) begin
            bus.bwd_valid = 1'b1;
            bus.bwd_delta = 32'h40000000;
            #1;
            checks++;
            if (bus.bwd_ready !== 1'b1) begin errors++; $display("FAIL gate_bwd_ready[%0d]: got %b want 1", i, bus.bwd_ready); end
            step();
        end
        bus.bwd_valid = 1'b0;
        step();
        step();
        checks++;
        if (obs_q.size() != 6) begin
            errors++;
            $display("FAIL gate_n_out: got %0d outputs want 6", obs_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_q[i] !== req[i]) begin errors++; $display("FAIL gate_out[%0d]: got %h want %h", i, obs_q[i], req[i]); end
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 64; i++) begin
            bus.fwd_valid = 1'b1;
            bus.fwd_z     = 32'h3F800000 + i;
            step();
        end
        checks += 2;
        if (mask_count !== 7'd64)   begin errors++; $display("FAIL full_count: got %0d want 64", mask_count); end
        if (bus.fwd_ready !== 1'b0) begin errors++; $display("FAIL full_fwd_ready: got %b want 0", bus.fwd_ready); end
        bus.fwd_z = 32'hBF800000;
        step();
        checks++;
        if (mask_count !== 7'd64) begin errors++; $display("FAIL full_ignore: got %0d want 64", mask_count); end
        bus.fwd_z     = 32'h3F800000;
        bus.bwd_valid = 1'b1;
        bus.bwd_delta = 32'h12345678;
        bus.out_ready = 1'b0;
        #1;
        checks += 2;
        if (bus.fwd_ready !== 1'b0) begin errors++; $display("FAIL full_pop_fwd_ready: got %b want 0", bus.fwd_ready); end
        if (bus.bwd_ready !== 1'b1) begin errors++; $display("FAIL full_pop_bwd_ready: got %b want 1", bus.bwd_ready); end
        step();
        bus.fwd_valid = 1'b0;
        bus.bwd_delta = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks += 3;
            if (bus.bwd_ready !== 1'b0)        begin errors++; $display("FAIL bp_bwd_ready[%0d]: got %b want 0", i, bus.bwd_ready); end
            if (bus.out_valid !== 1'b1)        begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus.out_valid); end
            if (bus.out_data !== 32'h12345678) begin errors++; $display("FAIL bp_hold[%0d]: got %h want 12345678", i, bus.out_data); end
            step();
        end
        checks++;
        if (mask_count !== 7'd63) begin errors++; $display("FAIL bp_count: got %0d want 63", mask_count); end
        bus.bwd_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        for (int i = 0; i < 63; i++) begin
            bus.bwd_valid = 1'b1;
            bus.bwd_delta = 32'hA5000000 | i;
            step();
        end
        bus.bwd_valid = 1'b0;
        step();
        step();
        checks += 2;
        if (mask_count !== 7'd0) begin errors++; $display("FAIL full_drain: got %0d want 0", mask_count); end
        if (exp_q.size() != 0)   begin errors++; $display("FAIL full_pending: %0d outputs missing", exp_q.size()); end
    endtask

    task automatic test_stream();
        logic [31:0] prev_delta;
        logic [31:0] want;
        bus.fwd_valid = 1'b1;
        bus.fwd_z = 32'h3F800000; step();
        bus.fwd_z = 32'hBF800000; step();
        bus.fwd_z = 32'h3F800000; step();
        prev_delta = 32'd0;
        for (int i = 0; i < 200; i++) begin
            bus.fwd_valid = 1'b1;
            bus.fwd_z     = i[0] ? 32'h40400000 : 32'hBF800000;
            bus.bwd_valid = 1'b1;
            bus.bwd_delta = $urandom;
            #1;
            checks += 3;
            if (bus.fwd_ready !== 1'b1) begin errors++; $display("FAIL str_fwd_ready[%0d]: got %b want 1", i, bus.fwd_ready); end
            if (bus.bwd_ready !== 1'b1) begin errors++; $display("FAIL str_bwd_ready[%0d]: got %b want 1", i, bus.bwd_ready); end
            if (mask_count !== 7'd3)    begin errors++; $display("FAIL str_count[%0d]: got %0d want 3", i, mask_count); end
            if (i > 0) begin
                want = ((i - 1) % 2 == 0) ? prev_delta : 32'd0;
                checks += 2;
                if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL str_gap[%0d]: out_valid=%b want 1", i, bus.out_valid); end
                if (bus.out_data !== want)  begin errors++; $display("FAIL str_alt[%0d]: got %h want %h", i, bus.out_data, want); end
            end
            prev_delta = bus.bwd_delta;
            step();
        end
        bus.fwd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.bwd_valid = 1'b1;
            bus.bwd_delta = 32'h3C000000 + i;
            step();
        end
        bus.bwd_valid = 1'b0;
        step();
        step();
        checks++;
        if (mask_count !== 7'd0) begin errors++; $display("FAIL str_drain: got %0d want 0", mask_count); end
    endtask

    task automatic test_underrun();
        bus.bwd_valid = 1'b1;
        bus.bwd_delta = 32'h3F800000;
        #1;
        checks += 2;
        if (bus.bwd_ready !== 1'b0) begin errors++; $display("FAIL ur_bwd_ready: got %b want 0", bus.bwd_ready); end
        if (err_underrun !== 1'b0)  begin errors++; $display("FAIL ur_err_pre: got %b want 0", err_underrun); end
        step();
        bus.bwd_valid = 1'b0;
        checks += 2;
        if (err_underrun !== 1'b1)  begin errors++; $display("FAIL ur_err_set: got %b want 1", err_underrun); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ur_no_out: out_valid=%b want 0", bus.out_valid); end
        step();
        checks++;
        if (err_underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b want 1", err_underrun); end
        bus.fwd_valid = 1'b1;
        bus.fwd_z     = 32'h40000000;
        step();
        bus.fwd_valid = 1'b0;
        bus.bwd_valid = 1'b1;
        bus.bwd_delta = 32'hC0400000;
        step();
        bus.bwd_valid = 1'b0;
        checks += 2;
        if (bus.out_data !== 32'hC0400000) begin errors++; $display("FAIL ur_recover: got %h want c0400000", bus.out_data); end
        if (err_underrun !== 1'b1)         begin errors++; $display("FAIL ur_sticky2: got %b want 1", err_underrun); end
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus.fwd_valid = 1'b1;
            bus.fwd_z     = i[0] ? 32'hC1000000 : 32'h41000000;
            step();
        end
        bus.fwd_valid = 1'b0;
        bus.bwd_valid = 1'b1;
        bus.bwd_delta = 32'h11111111;
        step();
        bus.bwd_valid = 1'b0;
        checks += 2;
        if (mask_count !== 7'd10)   begin errors++; $display("FAIL fl_pre_count: got %0d want 10", mask_count); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fl_pre_valid: got %b want 1", bus.out_valid); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks += 5;
        if (mask_count !== 7'd0)    begin errors++; $display("FAIL fl_count: got %0d want 0", mask_count); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", bus.out_valid); end
        if (bus.out_data !== 32'd0) begin errors++; $display("FAIL fl_data: got %h want 0", bus.out_data); end
        if (err_underrun !== 1'b0)  begin errors++; $display("FAIL fl_err: got %b want 0", err_underrun); end
        if (bus.bwd_ready !== 1'b0) begin errors++; $display("FAIL fl_bwd_ready: got %b want 0", bus.bwd_ready); end
        for (int i = 0; i < 3; i++) begin
            bus.fwd_valid = 1'b1;
            bus.fwd_z     = 32'h3F000000;
            step();
        end
        bus.fwd_valid = 1'b0;
        bus.bwd_valid = 1'b1;
        bus.bwd_delta = 32'h22222222;
        step();
        bus.bwd_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        checks += 4;
        if (mask_count !== 7'd0)    begin errors++; $display("FAIL ar_count: got %0d want 0", mask_count); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", bus.out_valid); end
        if (bus.out_data !== 32'd0) begin errors++; $display("FAIL ar_data: got %h want 0", bus.out_data); end
        if (bus.fwd_ready !== 1'b1) begin errors++; $display("FAIL ar_fwd_ready: got %b want 1", bus.fwd_ready); end
        mask_q.delete();
        exp_q.delete();
        mon_popped = 1'b0;
        #1 rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_simultaneous();
        bus.fwd_valid = 1'b1;
        bus.fwd_z     = 32'hBF800000;
        step();
        bus.fwd_z     = 32'h3F800000;
        bus.bwd_valid = 1'b1;
        bus.bwd_delta = 32'h40A00000;
        #1;
        checks += 2;
        if (bus.fwd_ready !== 1'b1) begin errors++; $display("FAIL sim_fwd_ready: got %b want 1", bus.fwd_ready); end
        if (bus.bwd_ready !== 1'b1) begin errors++; $display("FAIL sim_bwd_ready: got %b want 1", bus.bwd_ready); end
        step();
        bus.fwd_valid = 1'b0;
        checks += 3;
        if (mask_count !== 7'd1)    begin errors++; $display("FAIL sim_count: got %0d want 1", mask_count); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sim_valid: got %b want 1", bus.out_valid); end
        if (bus.out_data !== 32'd0) begin errors++; $display("FAIL sim_first: got %h want 0", bus.out_data); end
        step();
        bus.bwd_valid = 1'b0;
        checks += 2;
        if (bus.out_data !== 32'h40A00000) begin errors++; $display("FAIL sim_second: got %h want 40a00000", bus.out_data); end
        if (mask_count !== 7'd0)           begin errors++; $display("FAIL sim_empty: got %0d want 0", mask_count); end
        step();
        step();
    endtask

    initial begin
        set_idle();
        fork
            monitor();
        join_none
        test_reset();
        test_gating();
        test_full();
        test_stream();
        test_underrun();
        test_flush();
        test_simultaneous();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL end_pending: %0d outputs never seen", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/relu_grad_gate.md
Name: relu_grad_gate

Overview:
- Backward-pass neighbour of the ReLU stage: during the forward pass it records one "z > 0" mask bit per pre-activation value z.
- During the backward pass it gates each incoming gradient: delta passes where z > 0, otherwise it becomes +0.0.
- Mask bits are held in an internal FIFO, so the first forward element pairs with the first backward element.
- Sits between the ReLU layer's z stream and the upstream weight-gradient/MAC stage; IEEE-754 single precision.

Parameters:
- dataWidth, 32, width of z/delta words (FP32 layout; sign = MSB, exponent = next 8 bits).
- depth, 64, mask FIFO capacity in elements (power of 2, ≥2).
- cntWidth, $clog2(depth)+1, width of occupancy count.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of FIFO, output register and error flag
- fwd_valid  input  1  forward z valid
- fwd_z  input  dataWidth  pre-activation value z
- fwd_ready  output  1  mask FIFO can accept
- bwd_valid  input  1  gradient valid
- bwd_delta  input  dataWidth  upstream gradient dL/da
- bwd_ready  output  1  gradient accepted this cycle when bwd_valid is high
- out_valid  output  1  gated gradient valid
- out_data  output  dataWidth  gated gradient dL/dz
- out_ready  input  1  downstream accepts
- mask_count  output  cntWidth  stored mask bits
- err_underrun  output  1  sticky: bwd_valid high while FIFO empty and output stage free

Behaviour:
- Reset (rst = 0, async) forces all of the following; flush = 1 at a clock edge does the same synchronously and has priority over any push/pop that cycle:
  - FIFO empty; mask_count = 0.
  - out_valid = 0, out_data = 0, err_underrun = 0.
- Mask function, combinational on fwd_z: bit = 1 iff all three hold:
  - sign = 0;
  - bits[dataWidth-2:0] ≠ 0 (so ±0 gives 0);
  - not NaN (NaN = exponent all-ones with mantissa ≠ 0).
  - +inf gives 1; every negative value and every NaN gives 0.
- Push:
  - fwd_ready = (mask_count < depth).
  - Push occurs when fwd_valid & fwd_ready; write pointer increments mod depth.
  - fwd_ready stays low while full, even if a pop happens the same cycle.
- Pop / gate:
  - bwd_ready = (mask_count > 0) & (~out_valid | out_ready).
  - On bwd_valid & bwd_ready: head mask bit popped and read pointer increments mod depth.
  - Next cycle: out_valid = 1 and out_data = (mask ? bwd_delta : 0).
  - Latency is exactly 1 cycle from accept to out_valid.
- Output register:
  - Holds out_data stable while out_valid & ~out_ready.
  - Clears out_valid on out_ready unless a new pop happens the same cycle.
  - Back-to-back throughput is 1 element/cycle.
- Simultaneous push and pop: mask_count unchanged; pointers both advance.
- Pop while the FIFO holds exactly one element and a push arrives the same cycle: the pop takes the stored head bit and the new bit is stored normally. There is no bypass.
- Full: depth pushes without pops gives mask_count = depth and fwd_ready = 0; fwd_z is ignored.
- Empty: bwd_ready = 0.
  - If bwd_valid is high while empty and (~out_valid | out_ready), err_underrun sets and stays set until reset/flush.
  - Data is not consumed.
- Pointer wrap: pointers are log2(depth) bits and wrap naturally; count is tracked separately.
- No arithmetic is performed on delta; the bits pass through unchanged (including NaN/inf deltas when mask = 1).

Test Plan:
- Gating:
  - Push z = 3F800000 (1.0), BF800000 (−1.0), 00000000, 80000000, 7F800000 (+inf), 7FC00000 (NaN).
  - Then send six deltas of 40000000 (2.0).
  - Required out_data: 40000000, 0, 0, 0, 40000000, 0, each 1 cycle after acceptance.
- Full/backpressure:
  - Push 64 positive z with no pops: fwd_ready = 0, mask_count = 64.
  - 65th fwd_valid is ignored.
  - Hold out_ready = 0 after one pop: bwd_ready = 0 and out_data is stable until out_ready = 1.
- Streaming wrap:
  - 200 elements with fwd and bwd both active every cycle at alternating signs.
  - Required: outputs alternate delta/0 with no gaps; mask_count stays constant.
- Underrun: bwd_valid = 1 with an empty FIFO → bwd_ready = 0, err_underrun = 1 the next cycle and sticky; a later push then pop works normally.
- Flush/reset mid-operation:
  - Flush with 10 entries stored and out_valid = 1 → mask_count = 0, out_valid = 0, err_underrun = 0 next cycle.
  - Async rst pulse between edges → outputs clear immediately.
- Simultaneous edge: FIFO holds 1 entry (mask 0) while a push (mask 1) and a pop occur the same cycle → out_data = 0, mask_count stays 1, and the next pop yields delta.
